// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared types and defaults for the lock-in sweep sequencer
//
// Contents:
//   PERIOD_W       default width of a modulation period in main_clock cycles
//   SETTLE_CYCLES  default settle interval after a period change
//   STEP_W_MAX     widest step index carried in result_t
//   lockin_state_e sequencer FSM state encoding
//   result_t       one per-step result record {step, period, i, q}; the
//                  host-readout block packs records in this layout
package lockin_pkg;

  localparam int PERIOD_W      = 32;
  localparam int SETTLE_CYCLES = 5000;
  localparam int STEP_W_MAX    = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SETTLE    = 3'd2,
    S_INTEGRATE = 3'd3,
    S_LATCH     = 3'd4,
    S_CAPTURE   = 3'd5,
    S_EMIT      = 3'd6
  } lockin_state_e;

  typedef struct packed {
    logic [STEP_W_MAX-1:0] step;
    logic [PERIOD_W-1:0]   period;
    logic signed [31:0]    i;
    logic signed [31:0]    q;
  } result_t;

endpackage

// File: rtl/lockin_sweep_sequencer_period_table.sv
// rtl/lockin_sweep_sequencer_period_table.sv - modulation period table register file
//
// Ports:
//   main_clock, reset  clock and synchronous active-high reset (table -> all zero)
//   we, waddr, wdata   synchronous write port
//   raddr, rdata       combinational read port
module period_table #(
  parameter int  NUM_STEPS = 8,
  parameter int  PERIOD_W  = 32,
  localparam int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                main_clock,
  input  logic                reset,
  input  logic                we,
  input  logic [STEP_W-1:0]   waddr,
  input  logic [PERIOD_W-1:0] wdata,
  input  logic [STEP_W-1:0]   raddr,
  output logic [PERIOD_W-1:0] rdata
);

  logic [PERIOD_W-1:0] mem [NUM_STEPS];

  always_ff @(posedge main_clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_STEPS; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lockin_sweep_sequencer.sv
// rtl/lockin_sweep_sequencer.sv - steps the modulation period table and emits one I/Q record per step
//
// Ports:
//   main_clock, reset                  sole clock, synchronous active-high reset
//   start, abort                       sweep control (start honoured only in IDLE)
//   integration_cycles                 integration length, sampled when start is accepted
//   cfg_we, cfg_addr, cfg_period       period table write port, dropped while busy
//   dp_period, dp_clear, dp_latch      modulation/counter datapath control
//   dp_i, dp_q                         datapath results, valid the cycle after dp_latch
//   res_valid, res_ready               result record handshake
//   res_step, res_period, res_i, res_q result record
//   busy, sweep_done                   status
module lockin_sweep_sequencer #(
  parameter int  NUM_STEPS     = 8,
  parameter int  SETTLE_CYCLES = lockin_pkg::SETTLE_CYCLES,
  parameter int  PERIOD_W      = lockin_pkg::PERIOD_W,
  localparam int STEP_W        = $clog2(NUM_STEPS)
) (
  input  logic                main_clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [63:0]         integration_cycles,
  input  logic                cfg_we,
  input  logic [STEP_W-1:0]   cfg_addr,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [PERIOD_W-1:0] dp_period,
  output logic                dp_clear,
  output logic                dp_latch,
  input  logic signed [31:0]  dp_i,
  input  logic signed [31:0]  dp_q,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [STEP_W-1:0]   res_step,
  output logic [PERIOD_W-1:0] res_period,
  output logic signed [31:0]  res_i,
  output logic signed [31:0]  res_q,
  output logic                busy,
  output logic                sweep_done
);

  import lockin_pkg::*;

  localparam logic [2:0]  ST_IDLE      = S_IDLE;
  localparam logic [2:0]  ST_LOAD      = S_LOAD;
  localparam logic [2:0]  ST_SETTLE    = S_SETTLE;
  localparam logic [2:0]  ST_INTEGRATE = S_INTEGRATE;
  localparam logic [2:0]  ST_LATCH     = S_LATCH;
  localparam logic [2:0]  ST_CAPTURE   = S_CAPTURE;
  localparam logic [2:0]  ST_EMIT      = S_EMIT;
  localparam logic [63:0] SETTLE_LAST  = 64'(SETTLE_CYCLES - 1);

  logic [2:0]          state;
  // One extra bit so the index can reach NUM_STEPS, which terminates the sweep.
  logic [STEP_W:0]     step;
  logic [63:0]         cnt;
  logic [63:0]         integ_len;
  logic [PERIOD_W-1:0] tbl_rdata;
  logic                tbl_we;
  logic                sweep_end;
  logic                settle_last;
  logic                integ_last;

  assign tbl_we = cfg_we && (state == ST_IDLE);

  period_table #(
    .NUM_STEPS (NUM_STEPS),
    .PERIOD_W  (PERIOD_W)
  ) u_period_table (
    .main_clock (main_clock),
    .reset      (reset),
    .we         (tbl_we),
    .waddr      (cfg_addr),
    .wdata      (cfg_period),
    .raddr      (step[STEP_W-1:0]),
    .rdata      (tbl_rdata)
  );

  // NUM_STEPS is a power of two, so the top bit alone marks step == NUM_STEPS.
  // Periods below 2 cannot produce a modulation and act as end-of-table markers.
  assign sweep_end   = step[STEP_W] || (tbl_rdata < PERIOD_W'(2));
  assign settle_last = (cnt == SETTLE_LAST);
  assign integ_last  = (cnt == integ_len - 64'd1);

  // Strobes decode the registered state so dp_clear lands in the last settle
  // clock and dp_latch in the clock right after the last integration clock.
  assign busy     = (state != ST_IDLE);
  assign dp_clear = (state == ST_SETTLE) && settle_last;
  assign dp_latch = (state == ST_LATCH);

  always_ff @(posedge main_clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      step       <= '0;
      cnt        <= '0;
      integ_len  <= 64'd1;
      dp_period  <= '0;
      res_valid  <= 1'b0;
      res_step   <= '0;
      res_period <= '0;
      res_i      <= '0;
      res_q      <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // dp_period is left alone so the modulator keeps its last period.
        state     <= ST_IDLE;
        res_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state     <= ST_LOAD;
              step      <= '0;
              integ_len <= (integration_cycles == 64'd0) ? 64'd1 : integration_cycles;
            end
          end
          ST_LOAD: begin
            if (sweep_end) begin
              state      <= ST_IDLE;
              sweep_done <= 1'b1;
            end else begin
              dp_period <= tbl_rdata;
              cnt       <= '0;
              state     <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_last) begin
              cnt   <= '0;
              state <= ST_INTEGRATE;
            end else begin
              cnt <= cnt + 64'd1;
            end
          end
          ST_INTEGRATE: begin
            // Counter stops at integ_len-1, so it can never wrap.
            if (integ_last) begin
              state <= ST_LATCH;
            end else begin
              cnt <= cnt + 64'd1;
            end
          end
          ST_LATCH: begin
            state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            res_i      <= dp_i;
            res_q      <= dp_q;
            res_step   <= step[STEP_W-1:0];
            res_period <= dp_period;
            res_valid  <= 1'b1;
            state      <= ST_EMIT;
          end
          ST_EMIT: begin
            // Single-entry buffer: the next step is not loaded until the
            // current record has been taken.
            if (res_ready) begin
              res_valid <= 1'b0;
              step      <= step + 1'b1;
              state     <= ST_LOAD;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockin_sweep_sequencer.sv
// tb/tb_lockin_sweep_sequencer.sv - randomized self-checking bench for lockin_sweep_sequencer
module tb_lockin_sweep_sequencer;

  localparam int NS = 8;
  localparam int S  = 10;

  logic               main_clock;
  logic               reset;
  logic               start;
  logic               abort;
  logic [63:0]        integration_cycles;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic [31:0]        cfg_period;
  logic [31:0]        dp_period;
  logic               dp_clear;
  logic               dp_latch;
  logic signed [31:0] dp_i;
  logic signed [31:0] dp_q;
  logic               res_valid;
  logic               res_ready;
  logic [2:0]         res_step;
  logic [31:0]        res_period;
  logic signed [31:0] res_i;
  logic signed [31:0] res_q;
  logic               busy;
  logic               sweep_done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] tbl [NS];

  lockin_sweep_sequencer #(
    .NUM_STEPS     (NS),
    .SETTLE_CYCLES (S),
    .PERIOD_W      (32)
  ) dut (
    .main_clock         (main_clock),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .integration_cycles (integration_cycles),
    .cfg_we             (cfg_we),
    .cfg_addr           (cfg_addr),
    .cfg_period         (cfg_period),
    .dp_period          (dp_period),
    .dp_clear           (dp_clear),
    .dp_latch           (dp_latch),
    .dp_i               (dp_i),
    .dp_q               (dp_q),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_step           (res_step),
    .res_period         (res_period),
    .res_i              (res_i),
    .res_q              (res_q),
    .busy               (busy),
    .sweep_done         (sweep_done)
  );

  initial begin
    main_clock = 1'b0;
    forever #5 main_clock = ~main_clock;
  end

  always @(posedge main_clock) cyc <= cyc + 1;

  // Datapath results change every clock; only the value present in the
  // cycle after dp_latch may end up in a record.
  initial begin
    dp_i = '0;
    dp_q = '0;
    forever begin
      @(posedge main_clock);
      #1;
      dp_i = $urandom;
      dp_q = $urandom;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic write_tbl(input int a, input logic [31:0] d);
    @(posedge main_clock);
    #1;
    cfg_we     = 1'b1;
    cfg_addr   = a[2:0];
    cfg_period = d;
    tbl[a]     = d;
    @(posedge main_clock);
    #1;
    cfg_we = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready plus start/cfg_we/integration
  // noise while a record is stalled; 2: ready held low 50 cycles on record 0.
  // abort_after > 0 aborts that many cycles after the first LOAD.
  task automatic run_sweep(input int mode, input logic [63:0] icfg, input int abort_after);
    logic [63:0]        len;
    int                 n_exp, rec, load_cyc, clear_cyc, latch_cyc, rise0, abort_cyc, nclr, nlat;
    logic signed [31:0] cap_i, cap_q;
    logic               prev_valid, prev_stall, go_abort, quiet_bad, done;
    logic [98:0]        snap;
    len   = (icfg == 64'd0) ? 64'd1 : icfg;
    n_exp = 0;
    while (n_exp < NS && tbl[n_exp] >= 32'd2) n_exp++;
    rec = 0; clear_cyc = -1000; latch_cyc = -1000; rise0 = -1; abort_cyc = -1;
    nclr = 0; nlat = 0; cap_i = '0; cap_q = '0;
    prev_valid = 1'b0; prev_stall = 1'b0; go_abort = 1'b0; quiet_bad = 1'b0; done = 1'b0;
    snap = '0;
    @(posedge main_clock);
    #1;
    integration_cycles = icfg;
    start     = 1'b1;
    res_ready = (mode != 2);
    load_cyc  = cyc + 1;
    @(posedge main_clock);
    #1;
    start = 1'b0;
    integration_cycles = {$urandom, $urandom};
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge main_clock);
      if (rec == 0 && cyc == load_cyc) check_eq("busy_rise", busy, 1);
      if (cyc == latch_cyc + 1) begin
        cap_i = dp_i;
        cap_q = dp_q;
      end
      if (dp_clear) begin
        check_eq("clear_while_pending", res_valid, 0);
        clear_cyc = cyc;
        nclr++;
      end
      if (dp_latch) begin
        check_eq("integ_clocks", 64'(cyc - clear_cyc - 1), len);
        latch_cyc = cyc;
        nlat++;
      end
      if (res_valid && !prev_valid) begin
        if (rec == 0) rise0 = cyc;
        check_eq("record_expected", rec < n_exp, 1);
        check_eq("res_step", res_step, rec);
        if (rec < NS) check_eq("res_period", res_period, tbl[rec]);
        check_eq("res_i", res_i, cap_i);
        check_eq("res_q", res_q, cap_q);
        check_eq("valid_latency", 64'(cyc - load_cyc), 64'(S) + len + 64'd3);
        check_eq("clears_per_step", nclr, rec + 1);
        check_eq("latches_per_step", nlat, rec + 1);
      end
      if (res_valid && prev_stall) check_eq("stable_while_stalled", {res_step, res_period, res_i, res_q}, snap);
      snap       = {res_step, res_period, res_i, res_q};
      prev_stall = res_valid && !res_ready;
      prev_valid = res_valid;
      if (res_valid && res_ready) begin
        if (mode == 2 && rec == 0) check_eq("stall_length", cyc - rise0, 50);
        rec++;
        load_cyc = cyc + 1;
      end
      if (abort_cyc >= 0) begin
        if (cyc == abort_cyc + 1) begin
          check_eq("abort_busy", busy, 0);
          check_eq("abort_valid", res_valid, 0);
          check_eq("abort_period_held", dp_period, tbl[0]);
        end
        if (cyc > abort_cyc && (sweep_done || res_valid || busy)) quiet_bad = 1'b1;
        if (cyc == abort_cyc + 20) begin
          check_eq("abort_quiet", quiet_bad, 0);
          done = 1'b1;
        end
      end else if (sweep_done) begin
        check_eq("records_in_sweep", rec, n_exp);
        check_eq("done_timing", cyc, load_cyc + 1);
        check_eq("done_idle", busy, 0);
        done = 1'b1;
      end
      if (abort_after > 0 && abort_cyc < 0 && rec == 0 && cyc == load_cyc + abort_after) go_abort = 1'b1;
      @(posedge main_clock);
      #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      abort  = 1'b0;
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = (rec > 0) || (rise0 >= 0 && cyc - rise0 >= 50);
      endcase
      if (go_abort) begin
        abort     = 1'b1;
        abort_cyc = cyc;
        go_abort  = 1'b0;
      end
      if (mode == 1 && prev_stall) begin
        start              = 1'($urandom_range(0, 1));
        cfg_we             = 1'($urandom_range(0, 1));
        cfg_addr           = 3'($urandom_range(0, 7));
        cfg_period         = $urandom;
        integration_cycles = {$urandom, $urandom};
      end
    end
    check_eq("sweep_finished", done, 1);
  endtask

  initial begin
    logic got;
    reset = 1'b1; start = 1'b0; abort = 1'b0; integration_cycles = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_period = '0; res_ready = 1'b0;
    for (int k = 0; k < NS; k++) tbl[k] = '0;
    repeat (3) @(posedge main_clock);
    @(negedge main_clock);
    check_eq("reset_outputs",
             {dp_period, dp_clear, dp_latch, res_valid, res_step, res_period, res_i, res_q, busy, sweep_done}, 0);
    @(posedge main_clock);
    #1;
    reset = 1'b0;

    // Two-entry table, ready high, then back-pressure, then zero integration.
    for (int k = 0; k < NS; k++) write_tbl(k, (k == 0) ? 32'd1000 : (k == 1) ? 32'd500 : 32'd0);
    run_sweep(0, 64'd100, 0);
    run_sweep(2, 64'd100, 0);
    run_sweep(0, 64'd0, 0);

    // start and abort together in IDLE must not launch a sweep.
    @(posedge main_clock);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge main_clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge main_clock);
    check_eq("start_with_abort_idle", busy, 0);

    // Full table, random back-pressure and busy-time noise.
    for (int k = 0; k < NS; k++) write_tbl(k, 32'd4);
    run_sweep(1, 64'd5, 0);

    // Abort mid-integration, then a clean restart from step 0.
    write_tbl(0, 32'd1000);
    write_tbl(1, 32'd500);
    write_tbl(2, 32'd0);
    run_sweep(0, 64'd100, S + 31);
    run_sweep(0, 64'd7, 0);

    // Random tables, including early terminators.
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 9) == 0) write_tbl(k, 32'($urandom_range(0, 1)));
        else write_tbl(k, 32'($urandom_range(2, 60)));
      end
      run_sweep(1, 64'($urandom_range(0, 20)), 0);
    end

    // Reset while a record is waiting in EMIT.
    @(posedge main_clock);
    #1;
    integration_cycles = 64'd3;
    start     = 1'b1;
    res_ready = 1'b0;
    @(posedge main_clock);
    #1;
    start = 1'b0;
    got   = 1'b0;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge main_clock);
      got = res_valid;
    end
    check_eq("emit_reached", got, 1);
    @(posedge main_clock);
    #1;
    reset = 1'b1;
    @(posedge main_clock);
    #1;
    reset = 1'b0;
    @(negedge main_clock);
    check_eq("reset_mid_emit",
             {dp_period, dp_clear, dp_latch, res_valid, res_step, res_period, res_i, res_q, busy, sweep_done}, 0);
    for (int k = 0; k < NS; k++) tbl[k] = '0;
    run_sweep(0, 64'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
